// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: aligns/replicates stores, extracts and extends loads,
// and stalls the pipeline through an IDLE -> BUSY -> DONE handshake with the memory.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  MemByte,
    input  logic                  MemHalf,
    input  logic                  MemSignExt,
    input  logic [31:0]           Address,
    input  logic [31:0]           WriteData,
    output logic [31:0]           ReadData,
    output logic                  M_Stall,
    output logic                  Unaligned,
    output logic [ADDR_WIDTH-1:0] DataMem_Addr,
    output logic                  DataMem_Read,
    output logic [3:0]            DataMem_WE,
    output logic [31:0]           DataMem_Out,
    input  logic [31:0]           DataMem_In,
    input  logic                  DataMem_Ack
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t      state;
    logic        acc_byte;
    logic        acc_half;
    logic        acc_sext;
    logic [1:0]  acc_off;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        req;
    logic        misaligned;
    logic        issue;
    logic [3:0]  we_nxt;
    logic [31:0] out_nxt;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;

    // Byte wins when both size flags are set.
    assign is_byte    = MemByte;
    assign is_half    = MemHalf & ~MemByte;
    assign is_word    = ~MemByte & ~MemHalf;
    assign req        = MemRead | MemWrite;
    assign misaligned = (is_half & Address[0]) | (is_word & (Address[1:0] != 2'b00));
    assign issue      = (state == StIdle) & req & ~misaligned;

    assign M_Stall   = ~reset & (issue | (state == StBusy));
    assign Unaligned = ~reset & (state == StIdle) & req & misaligned;

    // Big-endian lanes: offset 0 is bits 31:24.
    always_comb begin
        we_nxt  = 4'b1111;
        out_nxt = WriteData;
        if (is_byte) begin
            out_nxt = {4{WriteData[7:0]}};
            unique case (Address[1:0])
                2'b00:   we_nxt = 4'b1000;
                2'b01:   we_nxt = 4'b0100;
                2'b10:   we_nxt = 4'b0010;
                default: we_nxt = 4'b0001;
            endcase
        end else if (is_half) begin
            out_nxt = {2{WriteData[15:0]}};
            we_nxt  = Address[1] ? 4'b0011 : 4'b1100;
        end
    end

    always_comb begin
        load_byte = 8'h00;
        unique case (acc_off)
            2'b00:   load_byte = DataMem_In[31:24];
            2'b01:   load_byte = DataMem_In[23:16];
            2'b10:   load_byte = DataMem_In[15:8];
            default: load_byte = DataMem_In[7:0];
        endcase
        load_half = acc_off[1] ? DataMem_In[15:0] : DataMem_In[31:16];
        if (acc_byte) begin
            load_val = {{24{acc_sext & load_byte[7]}}, load_byte};
        end else if (acc_half) begin
            load_val = {{16{acc_sext & load_half[15]}}, load_half};
        end else begin
            load_val = DataMem_In;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StIdle;
            ReadData     <= 32'h0;
            DataMem_Addr <= '0;
            DataMem_Read <= 1'b0;
            DataMem_WE   <= 4'b0000;
            DataMem_Out  <= 32'h0;
            acc_byte     <= 1'b0;
            acc_half     <= 1'b0;
            acc_sext     <= 1'b0;
            acc_off      <= 2'b00;
        end else begin
            unique case (state)
                StIdle: begin
                    if (issue) begin
                        DataMem_Addr <= Address[ADDR_WIDTH+1:2];
                        DataMem_Read <= MemRead;
                        // A simultaneous read and write performs only the read.
                        DataMem_WE   <= MemRead ? 4'b0000 : we_nxt;
                        DataMem_Out  <= out_nxt;
                        acc_byte     <= is_byte;
                        acc_half     <= is_half;
                        acc_sext     <= MemSignExt;
                        acc_off      <= Address[1:0];
                        state        <= StBusy;
                    end
                end
                StBusy: begin
                    if (DataMem_Ack) begin
                        if (DataMem_Read) begin
                            ReadData <= load_val;
                        end
                        DataMem_Read <= 1'b0;
                        DataMem_WE   <= 4'b0000;
                        state        <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expected load results are queued when a load is
// issued and popped when the controller reaches its completion cycle.
module tb_data_mem_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, MemByte, MemHalf, MemSignExt;
    logic [31:0] Address, WriteData, ReadData, DataMem_Out, DataMem_In;
    logic        M_Stall, Unaligned, DataMem_Read, DataMem_Ack;
    logic [29:0] DataMem_Addr;
    logic [3:0]  DataMem_WE;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb[$];
    logic [31:0] last_rd = 32'h0;

    data_mem_ctrl #(.ADDR_WIDTH(30)) dut (
        .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemByte(MemByte), .MemHalf(MemHalf), .MemSignExt(MemSignExt), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData), .M_Stall(M_Stall), .Unaligned(Unaligned),
        .DataMem_Addr(DataMem_Addr), .DataMem_Read(DataMem_Read), .DataMem_WE(DataMem_WE),
        .DataMem_Out(DataMem_Out), .DataMem_In(DataMem_In), .DataMem_Ack(DataMem_Ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_model(input bit by, input bit hf, input bit sx,
                                               input logic [31:0] addr, input logic [31:0] mem);
        logic [31:0] v;
        int sh;
        if (by) begin
            sh = 8 * (3 - int'(addr[1:0]));
            v = (mem >> sh) & 32'hFF;
            if (sx && v[7]) v = v | 32'hFFFF_FF00;
        end else if (hf) begin
            sh = addr[1] ? 0 : 16;
            v = (mem >> sh) & 32'hFFFF;
            if (sx && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    function automatic logic [3:0] we_model(input bit by, input bit hf, input logic [1:0] off);
        if (by) return 4'b1000 >> off;
        if (hf) return off[1] ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] out_model(input bit by, input bit hf, input logic [31:0] wd);
        if (by) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (hf) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    task automatic idle_inputs();
        MemRead = 0; MemWrite = 0; MemByte = 0; MemHalf = 0; MemSignExt = 0;
        Address = 0; WriteData = 0; DataMem_Ack = 0; DataMem_In = 32'h0BAD_F00D;
    endtask

    // One aligned access; the memory acks `delay` cycles after the request is registered.
    task automatic access(input bit rd, input bit wr, input bit by, input bit hf, input bit sx,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] mem, input int delay);
        logic [31:0] exp;
        @(posedge clock); #1;
        MemRead = rd; MemWrite = wr; MemByte = by; MemHalf = hf; MemSignExt = sx;
        Address = addr; WriteData = wd;
        if (rd) sb.push_back(load_model(by, hf, sx, addr, mem));
        @(negedge clock);
        check("stall_req", M_Stall, 1);
        check("unal_req", Unaligned, 0);
        for (int k = 1; k <= delay; k++) begin
            @(posedge clock); #1;
            DataMem_Ack = (k == delay);
            DataMem_In = (k == delay) ? mem : 32'h0BAD_F00D;
            @(negedge clock);
            check("stall_busy", M_Stall, 1);
            check("rd_busy", DataMem_Read, rd);
            check("we_busy", DataMem_WE, rd ? 4'b0000 : we_model(by, hf, addr[1:0]));
            check("addr_busy", DataMem_Addr, addr[31:2]);
            if (wr && !rd) check("out_busy", DataMem_Out, out_model(by, hf, wd));
        end
        @(posedge clock); #1;
        DataMem_Ack = 0; DataMem_In = 32'h0BAD_F00D;
        @(negedge clock);
        check("stall_done", M_Stall, 0);
        check("rd_done", DataMem_Read, 0);
        check("we_done", DataMem_WE, 0);
        if (rd) begin
            if (sb.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                exp = sb.pop_front();
                check("rdata_done", ReadData, exp);
                last_rd = exp;
            end
        end
        @(posedge clock); #1;
        idle_inputs();
        @(negedge clock);
        check("stall_idle", M_Stall, 0);
        check("rdata_hold", ReadData, last_rd);
    endtask

    task automatic misaligned(input bit rd, input bit hf, input logic [31:0] addr);
        @(posedge clock); #1;
        MemRead = rd; MemWrite = ~rd; MemHalf = hf; Address = addr; WriteData = 32'h1234_5678;
        @(negedge clock);
        check("unal_flag", Unaligned, 1);
        check("unal_stall", M_Stall, 0);
        @(posedge clock); #1;
        idle_inputs();
        @(negedge clock);
        check("unal_clear", Unaligned, 0);
        check("unal_noread", DataMem_Read, 0);
        check("unal_nowe", DataMem_WE, 0);
        check("unal_idle", M_Stall, 0);
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("rst_rdata", ReadData, 0);
        check("rst_stall", M_Stall, 0);
        check("rst_unal", Unaligned, 0);
        check("rst_addr", DataMem_Addr, 0);
        check("rst_read", DataMem_Read, 0);
        check("rst_we", DataMem_WE, 0);
        check("rst_out", DataMem_Out, 0);

        access(1, 0, 1, 0, 1, 32'h1003, 0, 32'h1234_56F0, 2);          // lb
        access(0, 1, 0, 1, 0, 32'h2002, 32'hAAAA_5678, 0, 1);          // sh
        misaligned(1, 0, 32'h0006);                                    // lw unaligned
        access(1, 0, 0, 1, 0, 32'h0000, 0, 32'h8001_FFFF, 1);          // lhu
        access(1, 0, 0, 1, 1, 32'h0002, 0, 32'h1234_8765, 1);          // lh
        access(1, 0, 1, 0, 0, 32'h0001, 0, 32'h12AB_3456, 3);          // lbu
        access(1, 0, 0, 0, 0, 32'h0010, 0, 32'hDEAD_BEEF, 1);          // lw
        access(0, 1, 1, 0, 0, 32'h0005, 32'h0000_00C3, 0, 2);          // sb
        access(0, 1, 0, 0, 0, 32'h0104, 32'hCAFE_BABE, 0, 1);          // sw
        access(1, 0, 1, 1, 1, 32'h0003, 0, 32'h0000_0080, 1);          // byte wins
        access(1, 1, 0, 0, 0, 32'h0020, 32'h5555_5555, 32'h0F0F_0F0F, 1); // read wins
        misaligned(0, 1, 32'h0201);                                    // sh unaligned

        // Stray ack in IDLE is ignored.
        @(posedge clock); #1;
        DataMem_Ack = 1; DataMem_In = 32'hFFFF_FFFF;
        @(negedge clock);
        check("ack_idle_stall", M_Stall, 0);
        @(posedge clock); #1;
        DataMem_Ack = 0;
        @(negedge clock);
        check("ack_idle_rdata", ReadData, last_rd);
        check("ack_idle_read", DataMem_Read, 0);

        // Reset while BUSY abandons the store; the late ack must not produce a DONE.
        @(posedge clock); #1;
        MemWrite = 1; Address = 32'h0040; WriteData = 32'h1357_9BDF;
        @(posedge clock); #1;
        @(negedge clock);
        check("rb_we", DataMem_WE, 4'b1111);
        check("rb_stall", M_Stall, 1);
        @(posedge clock); #1;
        reset = 1; MemWrite = 0;
        @(negedge clock);
        check("rb_stall_rst", M_Stall, 0);
        @(posedge clock); #1;
        reset = 0; DataMem_Ack = 1; DataMem_In = 32'hFFFF_FFFF;
        @(negedge clock);
        check("rb_we0", DataMem_WE, 0);
        check("rb_addr0", DataMem_Addr, 0);
        check("rb_out0", DataMem_Out, 0);
        check("rb_rdata0", ReadData, 0);
        @(posedge clock); #1;
        DataMem_Ack = 0;
        @(negedge clock);
        check("rb_nodone_rd", ReadData, 0);
        check("rb_nodone_read", DataMem_Read, 0);
        check("rb_stall_idle", M_Stall, 0);
        last_rd = 32'h0;

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, m;
            bit by, hf;
            by = $urandom_range(0, 1);
            hf = $urandom_range(0, 1);
            a = $urandom & 32'h0000_FFFF;
            if (!by && hf) a[0] = 1'b0;
            if (!by && !hf) a[1:0] = 2'b00;
            m = $urandom;
            access(1, 0, by, hf, $urandom_range(0, 1), a, 0, m, $urandom_range(1, 3));
        end

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
